mod_exp_ctrl: RTL and testbench
===============================

Name: mod_exp_ctrl

Overview:
- Computes result = base^exponent mod modulus for the key-exchange datapath: public key g^a mod p and shared secret B^a mod p.
- Uses right-to-left square-and-multiply.
- Every modular reduction goes through an external divider over a start/ready handshake; only the divider's remainder is used.
- Sits directly upstream of the divider, which is instantiated beside it at top level on the same clk and rst.

Parameters:
- WIDTH, 8, operand width of base, exponent, modulus and result. 2*WIDTH must not exceed 16, so a product fits the divider dividend.
- DIV_TIMEOUT, 63, maximum cycles spent waiting for div_ready before aborting with err.

Ports:
- clk  in  1  system clock, all state updates on posedge.
- rst  in  1  asynchronous active-high reset.
- start  in  1  request pulse, accepted only when busy=0.
- base  in  WIDTH  base operand, captured on accepted start.
- exponent  in  WIDTH  exponent, captured on accepted start.
- modulus  in  WIDTH  modulus, captured on accepted start.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle completion pulse.
- err  out  1  valid with done: modulus==0 or divider timeout.
- result  out  WIDTH  final value, held until the next accepted start.
- div_start  out  1  divider start level.
- div_dividend  out  16  dividend to divider, zero-extended.
- div_divider  out  16  {zeros, modulus}.
- div_remainder  in  16  divider remainder, valid when div_ready=1.
- div_ready  in  1  divider one-cycle completion pulse.

Behaviour:
- Reset (async) clears to 0: busy, done, err, result, div_start, div_dividend, div_divider, and all internal registers. State goes to IDLE. Reset mid-operation drops div_start at once; no partial result is reported.
- IDLE, start=1:
  - Capture operands; set acc=1.
  - If modulus==0: go to DONE with err=1, result=0.
  - Otherwise: issue REDUCE with dividend=base.
- Divider transaction, two states REQ then WAIT:
  - REQ: register div_dividend and div_divider, set div_start=1.
  - WAIT: hold div_start=1 and count cycles. On the cycle div_ready=1 is sampled, capture div_remainder[WIDTH-1:0] and clear div_start.
  - div_start must stay low for at least one full cycle before the next REQ, so the divider sees a fresh rising edge.
  - If the count reaches DIV_TIMEOUT, clear div_start and go to DONE with err=1, result=0.
- State sequence: IDLE -> REDUCE(b = base mod m) -> BIT -> {MUL} -> SHIFT -> {SQR} -> BIT ... -> DONE -> IDLE.
  - BIT: if e[0]=1, MUL: dividend = acc*b, acc = remainder.
  - SHIFT: e = e>>1. If e != 0, SQR: dividend = b*b, b = remainder, then return to BIT. If e == 0, go to DONE.
  - Exponent 0 skips all MUL/SQR: acc = 1 mod m, which is 0 when m=1 (one final reduction of acc through the divider covers this).
- Products are formed as WIDTH x WIDTH -> 2*WIDTH, unsigned. Intermediates are always < modulus.
- DONE:
  - result = acc, done=1 for exactly one cycle, busy drops in the same cycle, then IDLE.
  - start during busy or in DONE is ignored.
- A div_ready outside WAIT is ignored.
- Latency = transactions × (divider latency + 2) + small constant.
  - Transaction count = 1 (reduce) + popcount(exponent) + (bit-length(exponent) − 1) + 1 (final reduce of acc).

Decomposition:
- Shared package holds:
  - state encoding constants: IDLE, REDUCE, BIT, MUL, SHIFT, SQR, FIN, REQ, WAIT, GAP, DONE;
  - DIV_WIDTH = 16;
  - the default DIV_TIMEOUT.
- One sub-module is natural: div_if_seq, the REQ/WAIT/GAP handshake with watchdog.
  - Takes a request plus dividend.
  - Returns rem_valid / rem / timeout to the main FSM.

Test Plan:
- base=3, exp=5, mod=7 -> result=5, err=0, done once, exactly 6 div_start rising edges.
- base=5, exp=6, mod=23 -> result=8; base=20, exp=2, mod=7 -> result=1 (base reduced to 6 first).
- exp=0: mod=11 -> result=1; mod=1 -> result=0.
- mod=0 -> done with err=1, result=0, zero div_start edges.
- Divider model that never asserts ready -> done with err=1 after DIV_TIMEOUT cycles in WAIT, div_start low afterwards.
- rst asserted mid-SQR -> all outputs 0 immediately; restart with 5,6,23 -> result=8. A second start while busy is ignored.

Source files
------------

// File: rtl/mod_exp_ctrl_pkg.sv
// Shared definitions for the modular exponentiation controller.
//   DIV_WIDTH       : dividend/divisor/remainder width of the external divider
//   DEF_DIV_TIMEOUT : default watchdog limit, in cycles spent waiting for div_ready
//   state_e         : state encoding for the main FSM (IDLE..FIN, DONE) and the
//                     divider handshake sequencer (IDLE, REQ, WAIT, GAP)
package mod_exp_ctrl_pkg;

  localparam int unsigned DIV_WIDTH       = 16;
  localparam int unsigned DEF_DIV_TIMEOUT = 63;

  typedef enum logic [3:0] {
    IDLE,
    REDUCE,
    BIT,
    MUL,
    SHIFT,
    SQR,
    FIN,
    REQ,
    WAIT,
    GAP,
    DONE
  } state_e;

endpackage

// File: rtl/mod_exp_ctrl_div_if_seq.sv
// Divider handshake sequencer with watchdog.
// A one-cycle req latches dividend/divider, raises div_start and waits for div_ready.
//   clk, rst            : clock, asynchronous active-high reset
//   req                 : one-cycle request, only honoured while idle
//   dividend, divider   : operands latched on req
//   div_start           : level held high for the whole wait
//   div_dividend/_divider : registered operands presented to the divider
//   div_remainder/_ready  : divider response
//   rem_valid, rem      : one-cycle pulse with the low WIDTH bits of the remainder
//   timeout             : one-cycle pulse when div_ready never arrived
module mod_exp_ctrl_div_if_seq
  import mod_exp_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned DIV_TIMEOUT = DEF_DIV_TIMEOUT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req,
  input  logic [DIV_WIDTH-1:0] dividend,
  input  logic [DIV_WIDTH-1:0] divider,
  output logic                 div_start,
  output logic [DIV_WIDTH-1:0] div_dividend,
  output logic [DIV_WIDTH-1:0] div_divider,
  input  logic [DIV_WIDTH-1:0] div_remainder,
  input  logic                 div_ready,
  output logic                 rem_valid,
  output logic [WIDTH-1:0]     rem,
  output logic                 timeout
);

  localparam int unsigned CW = $clog2(DIV_TIMEOUT + 1);

  state_e          state_q;
  logic [CW-1:0]   wait_cnt_q;

  // Intermediates are always below the modulus, so the upper remainder bits carry nothing.
  logic unused_rem_hi;
  assign unused_rem_hi = ^div_remainder[DIV_WIDTH-1:WIDTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      wait_cnt_q   <= '0;
      div_start    <= 1'b0;
      div_dividend <= '0;
      div_divider  <= '0;
      rem_valid    <= 1'b0;
      rem          <= '0;
      timeout      <= 1'b0;
    end else begin
      rem_valid <= 1'b0;
      timeout   <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (req) begin
            div_dividend <= dividend;
            div_divider  <= divider;
            state_q      <= REQ;
          end
        end
        REQ: begin
          div_start  <= 1'b1;
          wait_cnt_q <= '0;
          state_q    <= WAIT;
        end
        WAIT: begin
          if (div_ready) begin
            rem       <= div_remainder[WIDTH-1:0];
            rem_valid <= 1'b1;
            div_start <= 1'b0;
            state_q   <= GAP;
          end else if (wait_cnt_q == CW'(DIV_TIMEOUT - 1)) begin
            timeout   <= 1'b1;
            div_start <= 1'b0;
            state_q   <= GAP;
          end else begin
            wait_cnt_q <= wait_cnt_q + 1'b1;
          end
        end
        // Guarantees div_start sits low for a full cycle so the next request is a fresh edge.
        GAP:     state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/mod_exp_ctrl.sv
// Right-to-left square-and-multiply modular exponentiation: result = base^exponent mod modulus.
// Every reduction is delegated to an external divider through mod_exp_ctrl_div_if_seq.
//   clk, rst                 : clock, asynchronous active-high reset
//   start                    : request pulse, accepted only while busy=0
//   base, exponent, modulus  : operands captured on an accepted start
//   busy                     : operation in progress
//   done, err                : one-cycle completion pulse; err flags modulus==0 or divider timeout
//   result                   : final value, held until the next completion
//   div_start, div_dividend, div_divider : request side of the divider handshake
//   div_remainder, div_ready : divider response
module mod_exp_ctrl
  import mod_exp_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned DIV_TIMEOUT = DEF_DIV_TIMEOUT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     base,
  input  logic [WIDTH-1:0]     exponent,
  input  logic [WIDTH-1:0]     modulus,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [WIDTH-1:0]     result,
  output logic                 div_start,
  output logic [DIV_WIDTH-1:0] div_dividend,
  output logic [DIV_WIDTH-1:0] div_divider,
  input  logic [DIV_WIDTH-1:0] div_remainder,
  input  logic                 div_ready
);

  localparam int unsigned PW = 2 * WIDTH;

  state_e                state_q;
  logic [WIDTH-1:0]      acc_q;
  logic [WIDTH-1:0]      b_q;
  logic [WIDTH-1:0]      e_q;
  logic [WIDTH-1:0]      m_q;
  logic                  fail_q;
  logic                  req_q;
  logic [DIV_WIDTH-1:0]  req_dividend_q;

  logic                  div_rem_valid;
  logic [WIDTH-1:0]      div_rem;
  logic                  div_timeout;

  logic [PW-1:0]         acc_b_prod;
  logic [PW-1:0]         b_sq_prod;
  logic [WIDTH-1:0]      e_shr;

  assign acc_b_prod = PW'(acc_q) * PW'(b_q);
  assign b_sq_prod  = PW'(b_q) * PW'(b_q);
  assign e_shr      = e_q >> 1;

  mod_exp_ctrl_div_if_seq #(
    .WIDTH       (WIDTH),
    .DIV_TIMEOUT (DIV_TIMEOUT)
  ) u_div_if_seq (
    .clk           (clk),
    .rst           (rst),
    .req           (req_q),
    .dividend      (req_dividend_q),
    .divider       (DIV_WIDTH'(m_q)),
    .div_start     (div_start),
    .div_dividend  (div_dividend),
    .div_divider   (div_divider),
    .div_remainder (div_remainder),
    .div_ready     (div_ready),
    .rem_valid     (div_rem_valid),
    .rem           (div_rem),
    .timeout       (div_timeout)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      acc_q          <= '0;
      b_q            <= '0;
      e_q            <= '0;
      m_q            <= '0;
      fail_q         <= 1'b0;
      req_q          <= 1'b0;
      req_dividend_q <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      err            <= 1'b0;
      result         <= '0;
    end else begin
      req_q <= 1'b0;
      done  <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            acc_q <= WIDTH'(1);
            e_q   <= exponent;
            m_q   <= modulus;
            busy  <= 1'b1;
            err   <= 1'b0;
            if (modulus == '0) begin
              fail_q  <= 1'b1;
              state_q <= DONE;
            end else begin
              req_q          <= 1'b1;
              req_dividend_q <= DIV_WIDTH'(base);
              state_q        <= REDUCE;
            end
          end
        end
        REDUCE: begin
          if (div_timeout) begin
            fail_q  <= 1'b1;
            state_q <= DONE;
          end else if (div_rem_valid) begin
            b_q     <= div_rem;
            state_q <= BIT;
          end
        end
        BIT: begin
          if (e_q[0]) begin
            req_q          <= 1'b1;
            req_dividend_q <= DIV_WIDTH'(acc_b_prod);
            state_q        <= MUL;
          end else begin
            state_q <= SHIFT;
          end
        end
        MUL: begin
          if (div_timeout) begin
            fail_q  <= 1'b1;
            state_q <= DONE;
          end else if (div_rem_valid) begin
            acc_q   <= div_rem;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          e_q   <= e_shr;
          req_q <= 1'b1;
          if (e_shr != '0) begin
            req_dividend_q <= DIV_WIDTH'(b_sq_prod);
            state_q        <= SQR;
          end else begin
            // Final reduction of acc covers exponent 0 with modulus 1 (1 mod 1 = 0).
            req_dividend_q <= DIV_WIDTH'(acc_q);
            state_q        <= FIN;
          end
        end
        SQR: begin
          if (div_timeout) begin
            fail_q  <= 1'b1;
            state_q <= DONE;
          end else if (div_rem_valid) begin
            b_q     <= div_rem;
            state_q <= BIT;
          end
        end
        FIN: begin
          if (div_timeout) begin
            fail_q  <= 1'b1;
            state_q <= DONE;
          end else if (div_rem_valid) begin
            acc_q   <= div_rem;
            state_q <= DONE;
          end
        end
        DONE: begin
          done    <= 1'b1;
          busy    <= 1'b0;
          err     <= fail_q;
          result  <= fail_q ? '0 : acc_q;
          fail_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mod_exp_ctrl.sv
// Bench for mod_exp_ctrl: behavioural divider model with random latency and stray
// ready pulses, plus a plain-arithmetic reference for the modular power.
module tb_mod_exp_ctrl;

  localparam int unsigned W   = 8;
  localparam int unsigned TMO = 63;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [W-1:0]  base = '0;
  logic [W-1:0]  exponent = '0;
  logic [W-1:0]  modulus = '0;
  logic          busy;
  logic          done;
  logic          err;
  logic [W-1:0]  result;
  logic          div_start;
  logic [15:0]   div_dividend;
  logic [15:0]   div_divider;
  logic [15:0]   div_remainder;
  logic          div_ready;

  int checks = 0;
  int failures = 0;

  // Divider model controls
  int lat = 1;
  bit never_ready = 1'b0;
  bit junk_en = 1'b0;
  int start_edges = 0;
  logic prev_start;
  bit pending;
  int pend_cnt;

  mod_exp_ctrl #(
    .WIDTH       (W),
    .DIV_TIMEOUT (TMO)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .base          (base),
    .exponent      (exponent),
    .modulus       (modulus),
    .busy          (busy),
    .done          (done),
    .err           (err),
    .result        (result),
    .div_start     (div_start),
    .div_dividend  (div_dividend),
    .div_divider   (div_divider),
    .div_remainder (div_remainder),
    .div_ready     (div_ready)
  );

  always #5 clk = ~clk;

  // Divider: answers lat+1 cycles after each div_start rising edge; while the controller
  // is idle it may emit stray ready pulses carrying garbage.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      div_ready     <= 1'b0;
      div_remainder <= '0;
      prev_start    <= 1'b0;
      pending       <= 1'b0;
      pend_cnt      <= 0;
    end else begin
      div_ready  <= 1'b0;
      prev_start <= div_start;
      if (div_start && !prev_start) begin
        start_edges <= start_edges + 1;
        pending     <= !never_ready;
        pend_cnt    <= lat;
      end else if (pending) begin
        if (pend_cnt == 0) begin
          div_ready     <= 1'b1;
          div_remainder <= (div_divider != 0) ? div_dividend % div_divider : 16'hFFFF;
          pending       <= 1'b0;
        end else begin
          pend_cnt <= pend_cnt - 1;
        end
      end else if (junk_en && !busy && ($urandom_range(0, 3) == 0)) begin
        div_ready     <= 1'b1;
        div_remainder <= 16'($urandom);
      end
    end
  end

  function automatic int ref_pow(input int b, input int e, input int m);
    int r;
    if (m == 0) return 0;
    r = 1 % m;
    for (int i = 0; i < e; i++) r = (r * b) % m;
    return r;
  endfunction

  function automatic int ref_edges(input int e, input int m);
    int pc = 0;
    int bl = 0;
    if (m == 0) return 0;
    for (int i = 0; i < 32; i++) begin
      if (((e >> i) & 1) != 0) begin
        pc++;
        bl = i + 1;
      end
    end
    return 2 + pc + ((bl > 1) ? bl - 1 : 0);
  endfunction

  // Runs one operation; optionally fires a second start while busy with other operands.
  task automatic run_op(input logic [W-1:0] b, input logic [W-1:0] e, input logic [W-1:0] m,
                        input bit poke, output logic [W-1:0] res, output logic er,
                        output int dones, output int edges, output logic busy_seen,
                        output logic busy_done, output bit timed_out);
    int e0;
    int tail;
    bit seen;
    @(negedge clk);
    e0 = start_edges;
    base = b; exponent = e; modulus = m; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    busy_seen = busy;
    if (poke) begin
      base = ~b; exponent = 8'd3; modulus = 8'd5; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    dones = 0; seen = 1'b0; tail = 0; timed_out = 1'b1;
    res = '0; er = 1'b0; busy_done = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if (done) begin
        dones++;
        if (!seen) begin
          seen = 1'b1; res = result; er = err; busy_done = busy; timed_out = 1'b0;
        end
      end
      if (seen) begin
        if (tail == 4) break;
        tail++;
      end
      @(negedge clk);
    end
    edges = start_edges - e0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, done, err, result, div_start, div_dividend, div_divider} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got busy=%b done=%b err=%b result=%0d div_start=%b dvd=%h dvs=%h, want all 0",
               busy, done, err, result, div_start, div_dividend, div_divider);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    logic [W-1:0] r; logic er, bs, bd; int d, ed; bit to;
    lat = 2;
    run_op(8'd3, 8'd5, 8'd7, 1'b0, r, er, d, ed, bs, bd, to);
    checks++; if (to || r !== 8'd5) begin failures++; $display("FAIL basic_result: got %0d (timeout=%0b), want 5", r, to); end
    checks++; if (er !== 1'b0) begin failures++; $display("FAIL basic_err: got %b, want 0", er); end
    checks++; if (d !== 1) begin failures++; $display("FAIL basic_done_count: got %0d, want 1", d); end
    checks++; if (ed !== 6) begin failures++; $display("FAIL basic_div_edges: got %0d, want 6", ed); end
    checks++; if (bs !== 1'b1) begin failures++; $display("FAIL basic_busy_after_start: got %b, want 1", bs); end
    checks++; if (bd !== 1'b0) begin failures++; $display("FAIL basic_busy_at_done: got %b, want 0", bd); end
  endtask

  task automatic test_vectors();
    logic [W-1:0] r; logic er, bs, bd; int d, ed; bit to;
    lat = 0;
    run_op(8'd5, 8'd6, 8'd23, 1'b0, r, er, d, ed, bs, bd, to);
    checks++; if (to || r !== 8'd8) begin failures++; $display("FAIL vec_5_6_23: got %0d (timeout=%0b), want 8", r, to); end
    lat = 4;
    run_op(8'd20, 8'd2, 8'd7, 1'b0, r, er, d, ed, bs, bd, to);
    checks++; if (to || r !== 8'd1) begin failures++; $display("FAIL vec_20_2_7: got %0d (timeout=%0b), want 1", r, to); end
    checks++; if (ed !== 4) begin failures++; $display("FAIL vec_20_2_7_edges: got %0d, want 4", ed); end
  endtask

  task automatic test_timeout();
    int hi = 0;
    int low_bad = 0;
    bit seen = 1'b0;
    logic [W-1:0] r = '1;
    logic er = 1'b0;
    never_ready = 1'b1;
    @(negedge clk);
    base = 8'd3; exponent = 8'd5; modulus = 8'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 500; i++) begin
      if (div_start) hi++;
      if (done) begin
        seen = 1'b1; r = result; er = err;
        break;
      end
      @(negedge clk);
    end
    repeat (5) begin
      @(negedge clk);
      if (div_start !== 1'b0) low_bad++;
    end
    never_ready = 1'b0;
    checks++; if (!seen || er !== 1'b1) begin failures++; $display("FAIL timeout_err: got err=%b seen=%0b, want err=1", er, seen); end
    checks++; if (r !== '0) begin failures++; $display("FAIL timeout_result: got %0d, want 0", r); end
    checks++; if (hi !== TMO) begin failures++; $display("FAIL timeout_wait_cycles: got %0d, want %0d", hi, TMO); end
    checks++; if (low_bad !== 0) begin failures++; $display("FAIL timeout_div_start_low: got %0d high samples, want 0", low_bad); end
  endtask

  task automatic test_exp_zero();
    logic [W-1:0] r; logic er, bs, bd; int d, ed; bit to;
    lat = 1;
    run_op(8'd9, 8'd0, 8'd1, 1'b0, r, er, d, ed, bs, bd, to);
    checks++; if (to || r !== 8'd0) begin failures++; $display("FAIL exp0_mod1: got %0d (timeout=%0b), want 0", r, to); end
    run_op(8'd9, 8'd0, 8'd11, 1'b0, r, er, d, ed, bs, bd, to);
    checks++; if (to || r !== 8'd1) begin failures++; $display("FAIL exp0_mod11: got %0d (timeout=%0b), want 1", r, to); end
    checks++; if (ed !== 2) begin failures++; $display("FAIL exp0_edges: got %0d, want 2", ed); end
  endtask

  task automatic test_mod_zero();
    logic [W-1:0] r; logic er, bs, bd; int d, ed; bit to;
    run_op(8'd4, 8'd3, 8'd0, 1'b0, r, er, d, ed, bs, bd, to);
    checks++; if (to || er !== 1'b1) begin failures++; $display("FAIL mod0_err: got %b (timeout=%0b), want 1", er, to); end
    checks++; if (r !== '0) begin failures++; $display("FAIL mod0_result: got %0d, want 0", r); end
    checks++; if (ed !== 0) begin failures++; $display("FAIL mod0_edges: got %0d, want 0", ed); end
    checks++; if (d !== 1) begin failures++; $display("FAIL mod0_done_count: got %0d, want 1", d); end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] r; logic er, bs, bd; int d, ed; bit to;
    logic [W-1:0] b, e, m;
    int sel;
    junk_en = 1'b1;
    for (int n = 0; n < 30; n++) begin
      lat = $urandom_range(0, 5);
      b = W'($urandom_range(0, 255));
      e = W'($urandom_range(0, 255));
      sel = $urandom_range(0, 9);
      m = (sel == 0) ? 8'd0 : (sel == 1) ? 8'd1 : W'($urandom_range(2, 255));
      run_op(b, e, m, 1'b0, r, er, d, ed, bs, bd, to);
      checks++;
      if (to || r !== W'(ref_pow(b, e, m))) begin
        failures++;
        $display("FAIL rand_result %0d^%0d mod %0d: got %0d (timeout=%0b), want %0d",
                 b, e, m, r, to, ref_pow(b, e, m));
      end
      checks++;
      if (er !== (m == 0)) begin failures++; $display("FAIL rand_err mod %0d: got %b, want %b", m, er, (m == 0)); end
      checks++;
      if (ed !== ref_edges(e, m)) begin
        failures++;
        $display("FAIL rand_edges exp %0d mod %0d: got %0d, want %0d", e, m, ed, ref_edges(e, m));
      end
      checks++;
      if (d !== 1) begin failures++; $display("FAIL rand_done_count: got %0d, want 1", d); end
    end
    junk_en = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] r; logic er, bs, bd; int d, ed; bit to;
    int e0;
    bit reached = 1'b0;
    lat = 3;
    run_op(8'd3, 8'd5, 8'd7, 1'b0, r, er, d, ed, bs, bd, to);
    checks++; if (to || r !== 8'd5) begin failures++; $display("FAIL pre_reset_result: got %0d, want 5", r); end
    @(negedge clk);
    e0 = start_edges;
    base = 8'd5; exponent = 8'd6; modulus = 8'd23; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    // Exponent 6 has bit 0 clear, so the second divider request is the first square.
    for (int i = 0; i < 400; i++) begin
      if (start_edges - e0 >= 2) begin
        reached = 1'b1;
        break;
      end
      @(negedge clk);
    end
    checks++;
    if (!reached || div_start !== 1'b1) begin
      failures++;
      $display("FAIL sqr_in_flight: got reached=%0b div_start=%b, want 1/1", reached, div_start);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({busy, done, err, result, div_start, div_dividend, div_divider} !== '0) begin
      failures++;
      $display("FAIL mid_reset_outputs: got busy=%b done=%b err=%b result=%0d div_start=%b dvd=%h dvs=%h, want all 0",
               busy, done, err, result, div_start, div_dividend, div_divider);
    end
    @(negedge clk);
    rst = 1'b0;
    run_op(8'd5, 8'd6, 8'd23, 1'b1, r, er, d, ed, bs, bd, to);
    checks++; if (to || r !== 8'd8) begin failures++; $display("FAIL restart_result: got %0d (timeout=%0b), want 8", r, to); end
    checks++; if (d !== 1) begin failures++; $display("FAIL restart_done_count: got %0d, want 1", d); end
    checks++; if (ed !== 6) begin failures++; $display("FAIL restart_edges: got %0d, want 6", ed); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_watchdog: simulation did not finish, want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_basic();
    test_vectors();
    test_timeout();
    test_exp_zero();
    test_mod_zero();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
